fpcmp_seq: RTL and testbench

- Request sequencer placed directly upstream of the floating-point compare unit (fpcmp).
- Accepts compare requests over a valid/ready handshake and registers the operands.
- Drives fpcmp's run/stall protocol, captures the result z and the 5 flags, and returns them over a valid/ready response channel.
- Also holds the sticky FP exception-flag register, per-flag trap enables and a completed-operation counter.

---
 rtl/fpcmp_seq_if.sv | 44 ++++
 rtl/fpcmp_seq.sv | 91 +++++++++
 tb/tb_fpcmp_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpcmp_seq_if.sv
// Request/compare/response bundle between the fpcmp sequencer and its neighbours.
// slave = sequencer side, master = requester/fpcmp/consumer side.
interface fpcmp_seq_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_pred;
  logic [31:0]      req_x;
  logic [31:0]      req_y;
  logic             cmp_run;
  logic             cmp_stall;
  logic [2:0]       cmp_pred;
  logic [31:0]      cmp_x;
  logic [31:0]      cmp_y;
  logic             cmp_z;
  logic [4:0]       cmp_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_z;
  logic [4:0]       rsp_flags;
  logic             rsp_trap;
  logic [4:0]       trap_en;
  logic             fsr_we;
  logic [4:0]       fsr_wdata;
  logic [4:0]       fsr_flags;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req_pred, req_x, req_y,
    input  cmp_stall, cmp_z, cmp_flags,
    input  rsp_ready, trap_en, fsr_we, fsr_wdata,
    output req_ready, cmp_run, cmp_pred, cmp_x, cmp_y,
    output rsp_valid, rsp_z, rsp_flags, rsp_trap, fsr_flags, op_count
  );

  modport master (
    output req_valid, req_pred, req_x, req_y,
    output cmp_stall, cmp_z, cmp_flags,
    output rsp_ready, trap_en, fsr_we, fsr_wdata,
    input  req_ready, cmp_run, cmp_pred, cmp_x, cmp_y,
    input  rsp_valid, rsp_z, rsp_flags, rsp_trap, fsr_flags, op_count
  );
endinterface

// File: rtl/fpcmp_seq.sv
// Sequences one compare at a time into fpcmp: accept -> run until stall drops -> hold response.
// Response visible one edge after an unstalled run; requests blocked until the response handshakes.
module fpcmp_seq #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fpcmp_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state;
  logic             r_cmp_run;
  logic [2:0]       r_cmp_pred;
  logic [31:0]      r_cmp_x;
  logic [31:0]      r_cmp_y;
  logic             r_rsp_valid;
  logic             r_rsp_z;
  logic [4:0]       r_rsp_flags;
  logic             r_rsp_trap;
  logic [4:0]       r_fsr_flags;
  logic [CNT_W-1:0] r_op_count;

  logic             w_done;
  logic [4:0]       w_fsr_base;

  assign w_done     = (r_state == RUN) && !bus.cmp_stall;
  // A software write on the completion edge is merged so no raised flag is lost.
  assign w_fsr_base = bus.fsr_we ? bus.fsr_wdata : r_fsr_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmp_run   <= 1'b0;
      r_cmp_pred  <= 3'd0;
      r_cmp_x     <= 32'd0;
      r_cmp_y     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_z     <= 1'b0;
      r_rsp_flags <= 5'd0;
      r_rsp_trap  <= 1'b0;
      r_fsr_flags <= 5'd0;
      r_op_count  <= '0;
    end else begin
      r_fsr_flags <= w_fsr_base | (w_done ? bus.cmp_flags : 5'd0);
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_cmp_pred <= bus.req_pred;
            r_cmp_x    <= bus.req_x;
            r_cmp_y    <= bus.req_y;
            r_cmp_run  <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (!bus.cmp_stall) begin
            r_rsp_z     <= bus.cmp_z;
            r_rsp_flags <= bus.cmp_flags;
            r_rsp_trap  <= |(bus.cmp_flags & bus.trap_en);
            r_rsp_valid <= 1'b1;
            r_cmp_run   <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.cmp_run   = r_cmp_run;
  assign bus.cmp_pred  = r_cmp_pred;
  assign bus.cmp_x     = r_cmp_x;
  assign bus.cmp_y     = r_cmp_y;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_z     = r_rsp_z;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.rsp_trap  = r_rsp_trap;
  assign bus.fsr_flags = r_fsr_flags;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_fpcmp_seq.sv
// Bench for fpcmp_seq: directed vector table, randomized ops against a transaction-level model,
// async reset mid-operation and counter wrap on a narrow-counter instance.
module tb_fpcmp_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpcmp_seq_if #(.CNT_W(16)) bus ();
  fpcmp_seq_if #(.CNT_W(4))  bus4 ();

  fpcmp_seq #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  fpcmp_seq #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    logic [2:0]  pred;
    logic [31:0] x;
    logic [31:0] y;
    int          stalls;
    logic        z;
    logic [4:0]  flags;
    logic [4:0]  ten;
    int          hold;
    logic        fwe;
    logic [4:0]  fwd;
    logic        pwe;
    logic [4:0]  pwd;
    logic        exp_trap;
    logic [4:0]  exp_fsr;
    logic [4:0]  exp_fsr_post;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: accept, run for v.stalls stalled edges, complete, hold, handshake.
  task automatic do_op(input vec_t v, input logic [15:0] exp_cnt);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_pred  = v.pred;
    bus.req_x     = v.x;
    bus.req_y     = v.y;
    bus.trap_en   = v.ten;
    bus.cmp_stall = 1'b1;
    bus.cmp_z     = ~v.z;
    bus.cmp_flags = ~v.flags;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_x     = $urandom;
    bus.req_y     = $urandom;
    bus.req_pred  = 3'($urandom);
    chk("run_after_accept", {31'd0, bus.cmp_run}, 32'd1);
    chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    chk("cmp_x", bus.cmp_x, v.x);
    chk("cmp_y", bus.cmp_y, v.y);
    chk("cmp_pred", {29'd0, bus.cmp_pred}, {29'd0, v.pred});
    for (int i = 0; i < v.stalls; i++) begin
      @(posedge clk); #1;
      chk("run_stalled", {31'd0, bus.cmp_run}, 32'd1);
      chk("cmp_x_stable", bus.cmp_x, v.x);
      chk("no_rsp_in_run", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.cmp_stall = 1'b0;
    bus.cmp_z     = v.z;
    bus.cmp_flags = v.flags;
    bus.fsr_we    = v.fwe;
    bus.fsr_wdata = v.fwd;
    @(posedge clk); #1;
    bus.cmp_stall = 1'b1;
    bus.cmp_z     = ~v.z;
    bus.cmp_flags = ~v.flags;
    bus.fsr_we    = 1'b0;
    bus.trap_en   = ~v.ten;
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("run_dropped", {31'd0, bus.cmp_run}, 32'd0);
    chk("rsp_z", {31'd0, bus.rsp_z}, {31'd0, v.z});
    chk("rsp_flags", {27'd0, bus.rsp_flags}, {27'd0, v.flags});
    chk("rsp_trap", {31'd0, bus.rsp_trap}, {31'd0, v.exp_trap});
    chk("fsr_flags", {27'd0, bus.fsr_flags}, {27'd0, v.exp_fsr});
    chk("op_count", {16'd0, bus.op_count}, {16'd0, exp_cnt});
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_x     = $urandom;
      @(posedge clk); #1;
      chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rsp_flags", {27'd0, bus.rsp_flags}, {27'd0, v.flags});
      chk("hold_rsp_trap", {31'd0, bus.rsp_trap}, {31'd0, v.exp_trap});
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("hold_cmp_x", bus.cmp_x, v.x);
    end
    bus.rsp_ready = 1'b1;
    bus.fsr_we    = v.pwe;
    bus.fsr_wdata = v.pwd;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.fsr_we    = 1'b0;
    chk("rsp_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    chk("no_early_accept", bus.cmp_x, v.x);
    chk("fsr_post", {27'd0, bus.fsr_flags}, {27'd0, v.exp_fsr_post});
    bus.req_valid = 1'b0;
  endtask

  vec_t        tbl[5];
  vec_t        rv;
  logic [4:0]  m_fsr;
  logic [15:0] m_cnt;
  logic [4:0]  wd;
  int          guard;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //             pred  x             y             st z     flags  ten    hold fwe   fwd    pwe   pwd    trap  fsr    post
    tbl[0] = '{3'd0, 32'h3F800000, 32'h3F800000, 0, 1'b1, 5'h00, 5'h00, 0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 5'h00};
    tbl[1] = '{3'd3, 32'h7FC00001, 32'h00000000, 3, 1'b0, 5'h10, 5'h10, 0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 5'h10, 5'h10};
    tbl[2] = '{3'd1, 32'h40000000, 32'h3F800000, 1, 1'b0, 5'h00, 5'h1F, 5, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 5'h10, 5'h10};
    tbl[3] = '{3'd2, 32'hBF800000, 32'h3F800000, 0, 1'b1, 5'h10, 5'h00, 0, 1'b1, 5'h01, 1'b1, 5'h00, 1'b0, 5'h11, 5'h00};
    tbl[4] = '{3'd4, 32'h00000001, 32'h80000000, 2, 1'b1, 5'h03, 5'h0C, 1, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 5'h03, 5'h03};

    bus.req_valid = 0; bus.req_pred = 0; bus.req_x = 0; bus.req_y = 0;
    bus.cmp_stall = 1; bus.cmp_z = 0; bus.cmp_flags = 0; bus.rsp_ready = 0;
    bus.trap_en = 0; bus.fsr_we = 0; bus.fsr_wdata = 0;
    bus4.req_valid = 0; bus4.req_pred = 0; bus4.req_x = 0; bus4.req_y = 0;
    bus4.cmp_stall = 0; bus4.cmp_z = 1; bus4.cmp_flags = 0; bus4.rsp_ready = 1;
    bus4.trap_en = 0; bus4.fsr_we = 0; bus4.fsr_wdata = 0;

    #1 rst = 1'b1;
    #11;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_cmp_run", {31'd0, bus.cmp_run}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_fsr", {27'd0, bus.fsr_flags}, 32'd0);
    chk("rst_op_count", {16'd0, bus.op_count}, 32'd0);
    chk("rst_cmp_x", bus.cmp_x, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) do_op(tbl[i], 16'(i + 1));

    // Random transactions against a transaction-level model.
    m_fsr = tbl[4].exp_fsr_post;
    m_cnt = 16'd5;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(3) == 0) begin
        wd = 5'($urandom);
        bus.fsr_we = 1'b1; bus.fsr_wdata = wd;
        @(posedge clk); #1;
        bus.fsr_we = 1'b0;
        m_fsr = wd;
        chk("idle_fsr_write", {27'd0, bus.fsr_flags}, {27'd0, m_fsr});
      end
      rv.pred   = 3'($urandom);
      rv.x      = $urandom;
      rv.y      = $urandom;
      rv.stalls = $urandom_range(4);
      rv.z      = 1'($urandom);
      rv.flags  = 5'($urandom);
      rv.ten    = 5'($urandom);
      rv.hold   = $urandom_range(3);
      rv.fwe    = ($urandom_range(3) == 0);
      rv.fwd    = 5'($urandom);
      rv.pwe    = ($urandom_range(7) == 0);
      rv.pwd    = 5'($urandom);
      rv.exp_trap = ((rv.flags & rv.ten) != 5'd0);
      m_fsr = (rv.fwe ? rv.fwd : m_fsr) | rv.flags;
      rv.exp_fsr = m_fsr;
      if (rv.pwe) m_fsr = rv.pwd;
      rv.exp_fsr_post = m_fsr;
      m_cnt = 16'((32'(m_cnt) + 1) % 65536);
      do_op(rv, m_cnt);
    end

    // Asynchronous reset while fpcmp is stalling.
    bus.req_valid = 1'b1; bus.req_x = 32'h12345678; bus.req_y = 32'h9ABCDEF0; bus.req_pred = 3'd5;
    bus.cmp_stall = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre_rst_run", {31'd0, bus.cmp_run}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_cmp_run", {31'd0, bus.cmp_run}, 32'd0);
    chk("arst_cmp_x", bus.cmp_x, 32'd0);
    chk("arst_cmp_y", bus.cmp_y, 32'd0);
    chk("arst_cmp_pred", {29'd0, bus.cmp_pred}, 32'd0);
    chk("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("arst_rsp_z", {31'd0, bus.rsp_z}, 32'd0);
    chk("arst_rsp_flags", {27'd0, bus.rsp_flags}, 32'd0);
    chk("arst_rsp_trap", {31'd0, bus.rsp_trap}, 32'd0);
    chk("arst_fsr", {27'd0, bus.fsr_flags}, 32'd0);
    chk("arst_op_count", {16'd0, bus.op_count}, 32'd0);
    chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    bus.cmp_stall = 1'b0; bus.cmp_flags = 5'h1F; bus.cmp_z = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    chk("post_rst_op_count", {16'd0, bus.op_count}, 32'd0);
    chk("post_rst_fsr", {27'd0, bus.fsr_flags}, 32'd0);

    // Back-to-back compares on the 4-bit counter instance.
    bus4.req_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      guard = 0;
      while (!bus4.rsp_valid && guard < 10) begin
        @(posedge clk); #1; guard++;
      end
      chk("wrap_rsp_seen", {31'd0, bus4.rsp_valid}, 32'd1);
      chk("wrap_op_count", {28'd0, bus4.op_count}, 32'(k % 16));
      @(posedge clk); #1;
    end
    bus4.req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
